// File: rtl/seven_seg_controller.sv
// Four-digit seven-segment scanner with a frame-synchronous shadow buffer. Outputs are registered and change on the scan tick.
// Host writes are never stalled; a write is shown from the next frame boundary on.
module seven_seg_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_blank,
  input  logic [3:0]  wr_dp,
  input  logic        lz_en,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        applied,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } disp_buf_t;

  localparam disp_buf_t BUF_RST = '{digits: 16'h0000, blank: 4'hF, dp: 4'h0};

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  disp_buf_t     shadow_q;
  disp_buf_t     disp_q;

  logic          tick;
  logic          boundary;
  logic          commit;
  logic [1:0]    idx_nxt;
  disp_buf_t     src;
  logic [3:0]    dark;
  logic          higher_clear;
  logic [3:0]    cur_digit;
  logic [6:0]    font;
  logic [3:0]    anode_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  always_comb begin
    tick     = (cnt == CNT_MAX);
    boundary = tick && (idx == 2'd3);
    commit   = boundary && pending;
    idx_nxt  = idx + 2'd1;
    // The first digit of a new frame must already see the freshly committed buffer.
    src      = commit ? shadow_q : disp_q;

    // Leading-zero suppression walks from the leftmost digit down; digit 0 is always shown.
    dark         = src.blank;
    higher_clear = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lz_en && (src.digits[4*i +: 4] == 4'h0) && higher_clear)
        dark[i] = 1'b1;
      higher_clear = higher_clear && ((src.digits[4*i +: 4] == 4'h0) || src.blank[i]);
    end

    cur_digit = src.digits[{idx_nxt, 2'b00} +: 4];
    case (cur_digit)
      4'h0:    font = 7'b1000000;
      4'h1:    font = 7'b1111001;
      4'h2:    font = 7'b0100100;
      4'h3:    font = 7'b0110000;
      4'h4:    font = 7'b0011001;
      4'h5:    font = 7'b0010010;
      4'h6:    font = 7'b0000010;
      4'h7:    font = 7'b1111000;
      4'h8:    font = 7'b0000000;
      4'h9:    font = 7'b0010000;
      4'hA:    font = 7'b0001000;
      4'hB:    font = 7'b0000011;
      4'hC:    font = 7'b1000110;
      4'hD:    font = 7'b0100001;
      4'hE:    font = 7'b0000110;
      default: font = 7'b0001110;
    endcase

    anode_nxt = ~(4'b0001 << idx_nxt);
    seg_nxt   = dark[idx_nxt] ? 7'b1111111 : font;
    dp_nxt    = dark[idx_nxt] | ~src.dp[idx_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 2'd0;
      anode       <= 4'b1110;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      pending     <= 1'b0;
      applied     <= 1'b0;
      frame_start <= 1'b0;
      shadow_q    <= BUF_RST;
      disp_q      <= BUF_RST;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      applied     <= commit;
      frame_start <= boundary;
      if (tick) begin
        idx   <= idx_nxt;
        anode <= anode_nxt;
        seg   <= seg_nxt;
        dp    <= dp_nxt;
      end
      if (commit)
        disp_q <= shadow_q;
      // A write on the boundary cycle lands in the shadow and waits for the next frame.
      if (wr_en) begin
        shadow_q <= '{digits: wr_data, blank: wr_blank, dp: wr_dp};
        pending  <= 1'b1;
      end else if (boundary) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_controller.sv
// Directed bench: SCAN_DIV=4 instance for scan/commit/blanking, SCAN_DIV=1 instance for the degenerate prescaler.
module tb_seven_seg_controller;
  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_blank;
  logic [3:0]  wr_dp;
  logic        lz_en;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        applied;
  logic        frame_start;

  logic        wr_en1;
  logic [15:0] wr_data1;
  logic [3:0]  wr_blank1;
  logic [3:0]  wr_dp1;
  logic        lz_en1;
  logic [3:0]  anode1;
  logic [6:0]  seg1;
  logic        dp1;
  logic        pending1;
  logic        applied1;
  logic        frame_start1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  seven_seg_controller #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_blank(wr_blank),
    .wr_dp(wr_dp), .lz_en(lz_en), .anode(anode), .seg(seg), .dp(dp),
    .pending(pending), .applied(applied), .frame_start(frame_start)
  );

  seven_seg_controller #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .wr_blank(wr_blank1),
    .wr_dp(wr_dp1), .lz_en(lz_en1), .anode(anode1), .seg(seg1), .dp(dp1),
    .pending(pending1), .applied(applied1), .frame_start(frame_start1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    wr_en    = 1'b1;
    wr_data  = d;
    wr_blank = b;
    wr_dp    = p;
    step();
    wr_en    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 16'h0; wr_blank = 4'h0; wr_dp = 4'h0; lz_en = 1'b0;
    wr_en1 = 1'b0; wr_data1 = 16'h0; wr_blank1 = 4'h0; wr_dp1 = 4'h0; lz_en1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_anode", 16'(anode), 16'b1110);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_applied", 16'(applied), 16'h0);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
    reset = 1'b0;
    cyc = 0;

    // Scan after release, no writes; SCAN_DIV=1 instance advances every edge.
    step();
    chk("div1_anode_c1", 16'(anode1), 16'b1101);
    step();
    chk("div1_anode_c2", 16'(anode1), 16'b1011);
    step();
    chk("anode_c3", 16'(anode), 16'b1110);
    chk("div1_anode_c3", 16'(anode1), 16'b0111);
    chk("div1_fs_c3", 16'(frame_start1), 16'h0);
    step();
    chk("anode_c4", 16'(anode), 16'b1101);
    chk("seg_c4", 16'(seg), 16'h7F);
    chk("div1_anode_c4", 16'(anode1), 16'b1110);
    chk("div1_fs_c4", 16'(frame_start1), 16'h1);
    step();
    chk("div1_fs_c5", 16'(frame_start1), 16'h0);
    run_to(8);
    chk("anode_c8", 16'(anode), 16'b1011);
    chk("div1_fs_c8", 16'(frame_start1), 16'h1);
    run_to(12);
    chk("anode_c12", 16'(anode), 16'b0111);
    chk("seg_c12", 16'(seg), 16'h7F);
    run_to(15);
    chk("fs_c15", 16'(frame_start), 16'h0);
    run_to(16);
    chk("anode_c16", 16'(anode), 16'b1110);
    chk("fs_c16", 16'(frame_start), 16'h1);
    chk("applied_c16", 16'(applied), 16'h0);

    // 0x12AF with dp on digit 1.
    write(16'h12AF, 4'b0000, 4'b0010);
    chk("fs_c17", 16'(frame_start), 16'h0);
    chk("pend_after_wr", 16'(pending), 16'h1);
    run_to(31);
    chk("pend_c31", 16'(pending), 16'h1);
    chk("applied_c31", 16'(applied), 16'h0);
    run_to(32);
    chk("applied_c32", 16'(applied), 16'h1);
    chk("pend_c32", 16'(pending), 16'h0);
    chk("fs_c32", 16'(frame_start), 16'h1);
    chk("seg_d0_F", 16'(seg), 16'b0001110);
    chk("dp_d0", 16'(dp), 16'h1);
    run_to(33);
    chk("applied_c33", 16'(applied), 16'h0);
    run_to(36);
    chk("seg_d1_A", 16'(seg), 16'b0001000);
    chk("dp_d1", 16'(dp), 16'h0);
    chk("anode_d1", 16'(anode), 16'b1101);
    run_to(40);
    chk("seg_d2_2", 16'(seg), 16'b0100100);
    chk("dp_d2", 16'(dp), 16'h1);
    run_to(44);
    chk("seg_d3_1", 16'(seg), 16'b1111001);
    chk("anode_d3", 16'(anode), 16'b0111);

    // Leading-zero suppression.
    lz_en = 1'b1;
    write(16'h0050, 4'b0000, 4'b0000);
    run_to(48);
    chk("lz_d0", 16'(seg), 16'b1000000);
    run_to(52);
    chk("lz_d1", 16'(seg), 16'b0010010);
    run_to(56);
    chk("lz_d2", 16'(seg), 16'h7F);
    chk("lz_d2_dp", 16'(dp), 16'h1);
    run_to(60);
    chk("lz_d3", 16'(seg), 16'h7F);
    write(16'h0000, 4'b0000, 4'b0000);
    run_to(64);
    chk("lz0_d0", 16'(seg), 16'b1000000);
    run_to(68);
    chk("lz0_d1", 16'(seg), 16'h7F);
    run_to(76);
    chk("lz0_d3", 16'(seg), 16'h7F);

    // Last write wins, single commit.
    write(16'h1111, 4'b0000, 4'b0000);
    write(16'h2222, 4'b0000, 4'b0000);
    run_to(79);
    chk("lww_applied_c79", 16'(applied), 16'h0);
    chk("lww_pend_c79", 16'(pending), 16'h1);
    run_to(80);
    chk("lww_applied_c80", 16'(applied), 16'h1);
    chk("lww_pend_c80", 16'(pending), 16'h0);
    chk("lww_d0", 16'(seg), 16'b0100100);
    run_to(81);
    chk("lww_applied_c81", 16'(applied), 16'h0);
    run_to(92);
    chk("lww_d3", 16'(seg), 16'b0100100);

    // Write on the boundary cycle defers to the next frame.
    run_to(95);
    write(16'h3333, 4'b0000, 4'b0000);
    chk("bnd_applied", 16'(applied), 16'h0);
    chk("bnd_fs", 16'(frame_start), 16'h1);
    chk("bnd_pend", 16'(pending), 16'h1);
    chk("bnd_seg_old", 16'(seg), 16'b0100100);
    run_to(111);
    chk("bnd_applied_c111", 16'(applied), 16'h0);
    run_to(112);
    chk("bnd_applied_next", 16'(applied), 16'h1);
    chk("bnd_seg_new", 16'(seg), 16'b0110000);
    chk("bnd_pend_clr", 16'(pending), 16'h0);

    // Mid-frame reset drops a pending write.
    write(16'h8888, 4'b0000, 4'b0000);
    chk("mr_pend", 16'(pending), 16'h1);
    run_to(118);
    chk("mr_pre_seg", 16'(seg), 16'b0110000);
    chk("mr_pre_anode", 16'(anode), 16'b1101);
    reset = 1'b1;
    #2;
    chk("mr_anode", 16'(anode), 16'b1110);
    chk("mr_seg", 16'(seg), 16'h7F);
    chk("mr_dp", 16'(dp), 16'h1);
    chk("mr_pend_clr", 16'(pending), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("mr_no_applied", 16'(applied), 16'h0);
      chk("mr_seg_dark", 16'(seg), 16'h7F);
    end
    run_to(20);
    chk("mr_anode_c20", 16'(anode), 16'b1101);
    run_to(32);
    chk("mr_fs_c32", 16'(frame_start), 16'h1);
    chk("mr_applied_c32", 16'(applied), 16'h0);
    chk("mr_pend_c32", 16'(pending), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
